spm_arbiter: RTL and testbench

//  Shares one 8-bit scratchpad memory (SPM) port among N_REQ requesters. Round-robin arbitration,
//  one access per cycle, optional burst lock. Sits between client engines and the SPM; drives the
//  SPM address/data_in/write and routes data_out back to the requester that issued the read.

---
 rtl/spm_pkg.sv | 18 +
 rtl/spm_rr_pick.sv | 31 +++
 rtl/spm_arbiter.sv | 140 ++++++++++++++
 tb/tb_spm_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// Shared types and default widths for the scratchpad-memory port arbiter.
package spm_pkg;

  localparam int SPM_AW = 8;
  localparam int SPM_DW = 8;

  typedef enum logic {
    ARB,
    LOCKED
  } spm_arb_state_t;

  typedef struct packed {
    logic              we;
    logic [SPM_AW-1:0] addr;
    logic [SPM_DW-1:0] wdata;
  } spm_cmd_t;

endpackage

// File: rtl/spm_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping N-1 -> 0.
module spm_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int cand;

  // Scan farthest-from-pointer first so the nearest requester is the last to overwrite.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr_i) + k) % N;
      if (req_i[cand]) begin
        idx_o = IW'(cand);
        any_o = 1'b1;
      end
    end
    if (any_o) onehot_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/spm_arbiter.sv
// Round-robin arbiter with burst lock sharing one SPM port; in-order command pipe and
// a two-stage read tag pipe route mem_data_out back to the issuing requester.
module spm_arbiter
  import spm_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int AW       = SPM_AW,
  parameter int DW       = SPM_DW,
  parameter int LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    lock,
  input  logic [N_REQ-1:0]    we,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic [AW-1:0]       mem_address,
  output logic [DW-1:0]       mem_data_in,
  output logic                mem_write,
  input  logic [DW-1:0]       mem_data_out
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  spm_arb_state_t   state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  cmd_t             cmd_q;
  logic [N_REQ-1:0] tag1_q, tag2_q;
  logic [DW-1:0]    rdata_q;

  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [IW-1:0]    win_idx;
  logic             granted;

  logic [AW-1:0] addr_a  [N_REQ];
  logic [DW-1:0] wdata_a [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_a[gi]  = addr[gi*AW +: AW];
    assign wdata_a[gi] = wdata[gi*DW +: DW];
  end

  spm_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt     = '0;
    if (!rst) begin
      case (state_q)
        ARB: begin
          if (pick_any) begin
            gnt   = pick_onehot;
            ptr_d = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            if (lock[pick_idx]) begin
              state_d = LOCKED;
              owner_d = pick_idx;
              cnt_d   = CW'(1);
            end
          end
        end
        LOCKED: begin
          // Pointer was left at owner+1 on entry, so the owner ends up lowest priority.
          if (req[owner_q]) begin
            gnt[owner_q] = 1'b1;
            cnt_d        = cnt_q + 1'b1;
            if (!lock[owner_q] || (cnt_q + 1'b1 == CW'(LOCK_MAX))) begin
              state_d = ARB;
              cnt_d   = '0;
            end
          end else begin
            state_d = ARB;
            cnt_d   = '0;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  assign win_idx = (state_q == LOCKED) ? owner_q : pick_idx;
  assign granted = |gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      cmd_q   <= '0;
      tag1_q  <= '0;
      tag2_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      if (granted) begin
        cmd_q <= '{we: we[win_idx], addr: addr_a[win_idx], wdata: wdata_a[win_idx]};
      end else begin
        cmd_q.we <= 1'b0;
      end
      tag1_q <= gnt & ~we;
      tag2_q <= tag1_q;
      if (|tag2_q) rdata_q <= mem_data_out;
    end
  end

  // SPM answers one cycle after the command, i.e. in the same cycle tag2 is live.
  assign rvalid      = tag2_q;
  assign rdata       = (|tag2_q) ? mem_data_out : rdata_q;
  assign mem_address = cmd_q.addr;
  assign mem_data_in = cmd_q.wdata;
  assign mem_write   = cmd_q.we;

endmodule

// File: tb/tb_spm_arbiter.sv
// Randomized and directed bench for spm_arbiter against a transaction-level reference model.
module tb_spm_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, lock, we;
  logic [31:0] addr, wdata;
  logic [3:0]  gnt, rvalid;
  logic [7:0]  rdata, mem_address, mem_data_in, mem_data_out;
  logic        mem_write;

  always #5 clk = ~clk;

  spm_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_write(mem_write), .mem_data_out(mem_data_out)
  );

  // Behavioural SPM: synchronous, data one cycle after the command.
  logic [7:0] spm [256];
  bit         spm_loaded;
  always @(posedge clk) begin
    if (!spm_loaded) begin
      for (int i = 0; i < 256; i++) spm[i] <= 8'(i * 37 + 11);
      spm_loaded <= 1'b1;
    end else begin
      mem_data_out <= spm[mem_address];
      if (mem_write) spm[mem_address] <= mem_data_in;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: memory image in grant order plus a queue of pending read returns.
  typedef struct {
    int         due;
    int         tag;
    logic [7:0] data;
  } rd_t;

  rd_t        rd_q[$];
  logic [7:0] ref_mem [256];
  int         cyc = 0;
  bit         m_init = 0;
  bit         m_locked;
  int         m_owner, m_ptr, m_run;
  logic       exp_mw;
  logic [7:0] last_addr, last_wdata, last_rdata;
  logic [3:0] obs_gnt;

  function automatic logic [3:0] model_gnt();
    if (rst) return 4'b0;
    if (m_locked) return req[m_owner] ? 4'(1 << m_owner) : 4'b0;
    for (int k = 0; k < 4; k++) begin
      if (req[(m_ptr + k) % 4]) return 4'(1 << ((m_ptr + k) % 4));
    end
    return 4'b0;
  endfunction

  task automatic step();
    logic [3:0] eg, erv;
    logic [7:0] erd, a, d;
    int         idx;
    #3;
    eg      = model_gnt();
    obs_gnt = gnt;
    check("gnt", 32'(gnt), 32'(eg));
    if (m_init) begin
      check("mem_write", 32'(mem_write), 32'(exp_mw));
      check("mem_address", 32'(mem_address), 32'(last_addr));
      check("mem_data_in", 32'(mem_data_in), 32'(last_wdata));
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        erv = 4'(1 << rd_q[0].tag);
        erd = rd_q[0].data;
      end else begin
        erv = 4'b0;
        erd = last_rdata;
      end
      check("rvalid", 32'(rvalid), 32'(erv));
      check("rdata", 32'(rdata), 32'(erd));
    end
    idx = 0;
    for (int i = 0; i < 4; i++) if (eg[i]) idx = i;
    if (eg != 0)
      $display("t=%0t gnt=%b we=%b addr=%h wdata=%h", $time, gnt, we[idx],
               addr[idx*8 +: 8], wdata[idx*8 +: 8]);
    @(posedge clk);
    if (rst) begin
      rd_q.delete();
      m_init = 1; m_locked = 0; m_owner = 0; m_ptr = 0; m_run = 0;
      exp_mw = 0; last_addr = 0; last_wdata = 0; last_rdata = 0;
    end else begin
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        last_rdata = rd_q[0].data;
        void'(rd_q.pop_front());
      end
      if (eg != 0) begin
        a = addr[idx*8 +: 8];
        d = wdata[idx*8 +: 8];
        if (we[idx]) ref_mem[a] = d;
        else rd_q.push_back('{cyc + 2, idx, ref_mem[a]});
        exp_mw = we[idx]; last_addr = a; last_wdata = d;
        if (!m_locked) begin
          m_ptr = (idx + 1) % 4;
          if (lock[idx]) begin m_locked = 1; m_owner = idx; m_run = 1; end
        end else begin
          m_run++;
          if (!lock[m_owner] || m_run == 16) m_locked = 0;
        end
      end else begin
        exp_mw = 0;
        if (m_locked && !req[m_owner]) m_locked = 0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1; req = 0; lock = 0; we = 0;
    for (int i = 0; i < n; i++) step();
    rst = 0;
  endtask

  logic [3:0] seq [5];
  int         g2;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
    rst = 1; req = 4'hF; lock = 0; we = 0; addr = 0; wdata = 0;
    @(posedge clk); #1;

    // Reset with all requests high, then first grant goes to requester 0.
    step(); step();
    rst = 0;
    step();
    check("t1_first_gnt", 32'(obs_gnt), 32'h1);

    // Round-robin over all-read requests.
    do_reset(1);
    req = 4'hF; we = 0; addr = 32'h3322_1100;
    for (int i = 0; i < 5; i++) begin step(); seq[i] = obs_gnt; end
    check("t2_rr0", 32'(seq[0]), 32'h1);
    check("t2_rr1", 32'(seq[1]), 32'h2);
    check("t2_rr2", 32'(seq[2]), 32'h4);
    check("t2_rr3", 32'(seq[3]), 32'h8);
    check("t2_rr4", 32'(seq[4]), 32'h1);
    req = 0;
    step(); step(); step();

    // Write then read the same address.
    do_reset(1);
    req = 4'b0001; we = 4'b0001; addr = 32'h0000_003C; wdata = 32'h0000_00A5;
    step();
    check("t3_mem_write", 32'(mem_write), 32'h1);
    check("t3_mem_addr", 32'(mem_address), 32'h3C);
    req = 4'b0010; we = 0; addr = 32'h0000_3C00;
    step();
    req = 0;
    step();
    check("t3_rvalid", 32'(rvalid), 32'h2);
    check("t3_rdata", 32'(rdata), 32'hA5);
    step();

    // Lock with forced release after 16 grants.
    do_reset(1);
    req = 4'b0101; lock = 4'b0100; we = 4'b0101; addr = 32'h0012_0034; wdata = 32'h0056_0078;
    g2 = 0;
    step();
    check("t4_first", 32'(obs_gnt), 32'h1);
    for (int i = 0; i < 16; i++) begin step(); if (obs_gnt == 4'b0100) g2++; end
    check("t4_run_len", 32'(g2), 32'd16);
    step();
    check("t4_release", 32'(obs_gnt), 32'h1);
    // Drop lock on the 5th grant of the next burst.
    g2 = 0;
    for (int i = 0; i < 10 && g2 < 5; i++) begin
      lock = (g2 == 4) ? 4'b0000 : 4'b0100;
      step();
      if (obs_gnt == 4'b0100) g2++;
    end
    check("t4_early_cnt", 32'(g2), 32'd5);
    lock = 4'b0100;
    step();
    check("t4_early_next", 32'(obs_gnt), 32'h1);
    req = 0; lock = 0;
    step(); step();

    // Reset drops an in-flight read.
    req = 4'b0001; we = 0; addr = 32'h0000_0010;
    step();
    rst = 1; req = 0;
    step();
    rst = 0;
    check("t5_rvalid", 32'(rvalid), 32'h0);
    check("t5_rdata", 32'(rdata), 32'h0);
    step();

    // Idle keeps pointer and address.
    req = 4'b0001; we = 0; addr = 32'h0000_0077;
    step();
    req = 0;
    for (int i = 0; i < 10; i++) step();
    check("t6_addr_hold", 32'(mem_address), 32'h77);
    req = 4'hF;
    step();
    check("t6_ptr_kept", 32'(obs_gnt), 32'h2);

    // Randomized traffic with a small address window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      rst  = ($urandom_range(0, 63) == 0);
      req  = 4'($urandom);
      lock = req & 4'($urandom) & 4'($urandom);
      we   = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        addr[i*8 +: 8]  = 8'($urandom_range(0, 7));
        wdata[i*8 +: 8] = 8'($urandom);
      end
      step();
    end
    rst = 0; req = 0;
    step(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
